// File: rtl/pc_gen.sv
// Fetch program-counter generator: trap/jump redirect, debug halt/resume FSM, redirect alignment check.
// Optional macro PC_RVC_EN: compressed-instruction increments (2 or 4) and 2-byte alignment.
module pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    HOLD_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [HOLD_WIDTH-1:0] hold_flag_i,
    input  logic                  jump_flag_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_flag_i,
    input  logic [ADDR_WIDTH-1:0] trap_addr_i,
    input  logic                  halt_req_i,
    input  logic                  resume_req_i,
    input  logic                  pc_ready_i,
`ifdef PC_RVC_EN
    input  logic                  inst_is_rvc_i,
`endif
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    output logic                  halted_o,
    output logic                  misalign_o
);

`ifdef PC_RVC_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`else
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b0}}, 2'b11};
`endif

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    hold;
    logic                    accept;
    logic                    redirect;
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic [ADDR_WIDTH-1:0]   inc;

    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

    assign hold            = |hold_flag_i;
    assign accept          = pc_valid_o && pc_ready_i;
    assign redirect        = trap_flag_i || jump_flag_i;
    // Trap wins over jump; only the winner is aligned and checked.
    assign redirect_target = trap_flag_i ? trap_addr_i : jump_addr_i;

`ifdef PC_RVC_EN
    assign inc = inst_is_rvc_i ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
`else
    assign inc = ADDR_WIDTH'(4);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (halt_req_i)   state_next = HALT;
            HALT:    if (resume_req_i) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pc_valid_o = 1'b0;
        halted_o   = 1'b0;
        case (state)
            RUN:     pc_valid_o = !hold;
            HALT:    halted_o   = 1'b1;
            default: ;
        endcase
    end

    // An un-accepted request keeps pc_o stable; only a redirect may retarget it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_o       <= RESET_ADDR;
            misalign_o <= 1'b0;
        end else if (state != BOOT) begin
            if (redirect) begin
                pc_o       <= align_addr(redirect_target);
                misalign_o <= is_misaligned(redirect_target);
            end else begin
                misalign_o <= 1'b0;
                if (!hold && accept) begin
                    pc_o <= pc_o + inc;
                end
            end
        end else begin
            misalign_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_gen;
    localparam int AW = 32;
    localparam int HW = 3;
`ifdef PC_RVC_EN
    localparam int ALIGN = 2;
`else
    localparam int ALIGN = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] hold = '0;
    logic          jump_flag = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          trap_flag = 1'b0;
    logic [AW-1:0] trap_addr = '0;
    logic          halt_req = 1'b0;
    logic          resume_req = 1'b0;
    logic          pc_ready = 1'b0;
`ifdef PC_RVC_EN
    logic          inst_is_rvc = 1'b0;
`endif
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          halted;
    logic          misalign;

    pc_gen #(.ADDR_WIDTH(AW), .HOLD_WIDTH(HW), .RESET_ADDR('0)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .hold_flag_i  (hold),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .trap_flag_i  (trap_flag),
        .trap_addr_i  (trap_addr),
        .halt_req_i   (halt_req),
        .resume_req_i (resume_req),
        .pc_ready_i   (pc_ready),
`ifdef PC_RVC_EN
        .inst_is_rvc_i(inst_is_rvc),
`endif
        .pc_o         (pc),
        .pc_valid_o   (pc_valid),
        .halted_o     (halted),
        .misalign_o   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic          valid;
        logic          halted;
        logic          mis;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: plain "booting / halted" flags and arithmetic on the PC.
    logic [AW-1:0] m_pc;
    bit            m_boot;
    bit            m_halt;
    bit            m_mis;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        bit            acc;
        logic [AW-1:0] t;
        int unsigned   step_sz;
        step_sz = 4;
`ifdef PC_RVC_EN
        if (inst_is_rvc) step_sz = 2;
`endif
        if (m_boot) begin
            m_boot = 0;
            m_mis  = 0;
        end else begin
            acc = !m_halt && (hold == 0) && pc_ready;
            if (trap_flag || jump_flag) begin
                t     = trap_flag ? trap_addr : jump_addr;
                m_pc  = t - (t % 32'(ALIGN));
                m_mis = (t % 32'(ALIGN)) != 0;
            end else begin
                m_mis = 0;
                if (acc) m_pc = m_pc + step_sz;
            end
            if (!m_halt) m_halt = halt_req;
            else         m_halt = !resume_req;
        end
        exp_q.push_back('{m_pc, !m_boot && !m_halt && (hold == 0), m_halt, m_mis});
    endtask

    // Monitor: outputs are compared mid-cycle against whatever the model pushed at the last edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_pc", pc, e.pc);
            chk("mon_valid", AW'(pc_valid), AW'(e.valid));
            chk("mon_halted", AW'(halted), AW'(e.halted));
            chk("mon_misalign", AW'(misalign), AW'(e.mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        jump_flag  = 1'b0;
        trap_flag  = 1'b0;
        halt_req   = 1'b0;
        resume_req = 1'b0;
    endtask

    task automatic reset_assert();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, '0);
        chk("rst_valid", AW'(pc_valid), '0);
        chk("rst_halted", AW'(halted), '0);
        chk("rst_misalign", AW'(misalign), '0);
    endtask

    task automatic reset_release();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        m_pc   = '0;
        m_boot = 1;
        m_halt = 0;
        m_mis  = 0;
        chk("boot_valid", AW'(pc_valid), '0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("init_pc", pc, '0);
        chk("init_valid", AW'(pc_valid), '0);
        chk("init_halted", AW'(halted), '0);
        reset_release();
        pc_ready = 1'b1;

        tick();
        chk("seq_pc0", pc, 32'h0);
        chk("seq_valid", AW'(pc_valid), 1);
        tick();
        chk("seq_pc4", pc, 32'h4);
        tick();
        chk("seq_pc8", pc, 32'h8);

        trap_flag = 1'b1; trap_addr = 32'h100;
        jump_flag = 1'b1; jump_addr = 32'h200;
        tick();
        chk("trap_over_jump", pc, 32'h100);
        clear_redirects();
        hold = 3'b010;
        tick();
        chk("hold_pc", pc, 32'h100);
        chk("hold_valid", AW'(pc_valid), 0);
        hold = '0;

        jump_flag = 1'b1; jump_addr = 32'h40;
        tick();
        clear_redirects();
        pc_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_pc", pc, 32'h40);
            chk("stall_valid", AW'(pc_valid), 1);
        end
        jump_flag = 1'b1; jump_addr = 32'h80;
        tick();
        chk("stall_retarget", pc, 32'h80);

        jump_addr = 32'hFFFF_FFFC;
        tick();
        clear_redirects();
        pc_ready = 1'b1;
        tick();
        chk("wrap_pc", pc, 32'h0);

        jump_flag = 1'b1; jump_addr = 32'h1003;
        tick();
`ifdef PC_RVC_EN
        chk("misalign_pc", pc, 32'h1002);
`else
        chk("misalign_pc", pc, 32'h1000);
`endif
        chk("misalign_pulse", AW'(misalign), 1);
        clear_redirects();
        pc_ready = 1'b0;
        tick();
        chk("misalign_clear", AW'(misalign), 0);

        jump_flag = 1'b1; jump_addr = 32'h10;
        tick();
        clear_redirects();
        pc_ready = 1'b1; halt_req = 1'b1;
        tick();
        chk("halt_pc", pc, 32'h14);
        chk("halt_flag", AW'(halted), 1);
        chk("halt_valid", AW'(pc_valid), 0);
        clear_redirects();
        pc_ready = 1'b0;
        jump_flag = 1'b1; jump_addr = 32'h300;
        tick();
        chk("halt_jump", pc, 32'h300);
        clear_redirects();
        resume_req = 1'b1;
        tick();
        chk("resume_pc", pc, 32'h300);
        chk("resume_valid", AW'(pc_valid), 1);
        resume_req = 1'b0;
        pc_ready = 1'b1;
        tick();
        chk("resume_fetch", pc, 32'h304);

        jump_flag = 1'b1; jump_addr = 32'h24; pc_ready = 1'b0;
        tick();
        clear_redirects();
        chk("pre_reset_pc", pc, 32'h24);
        reset_assert();
        reset_release();

        for (int i = 0; i < 800; i++) begin
            hold       = ($urandom_range(0, 3) == 0) ? HW'($urandom_range(1, 7)) : '0;
            jump_flag  = ($urandom_range(0, 7) == 0);
            jump_addr  = $urandom;
            trap_flag  = ($urandom_range(0, 15) == 0);
            trap_addr  = $urandom;
            halt_req   = ($urandom_range(0, 15) == 0);
            resume_req = ($urandom_range(0, 3) == 0);
            pc_ready   = ($urandom_range(0, 3) != 0);
`ifdef PC_RVC_EN
            inst_is_rvc = $urandom_range(0, 1) == 1;
`endif
            tick();
            if ($urandom_range(0, 99) == 0) begin
                reset_assert();
                reset_release();
            end
        end
        clear_redirects();
        @(negedge clk);
        #1;
        chk("queue_drained", AW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
